// File: rtl/alu_issue_queue.sv
// Operand issue queue in front of the ALU: circular FIFO of {op, a, b} plus an in-flight credit counter.
// Optional same-cycle bypass when empty: define ALU_ISSUE_BYPASS_EN.
module alu_issue_queue #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  a_in,
  input  logic [WIDTH-1:0]                  b_in,
  input  logic                              op_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [WIDTH-1:0]                  a_out,
  output logic [WIDTH-1:0]                  b_out,
  output logic                              op_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  input  logic                              ret_valid,
  output logic [$clog2(DEPTH+1)-1:0]        count_out,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned EW = 2 * WIDTH + 1;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_inflight;

  logic          w_empty;
  logic          w_credit;
  logic          w_bypass;
  logic          w_enq;
  logic          w_deq;
  logic          w_push;
  logic          w_pop;
  logic          w_ret;
  logic [EW-1:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_credit = (r_inflight < IW'(MAX_INFLIGHT));
  assign w_head   = r_mem[r_rd_ptr];

`ifdef ALU_ISSUE_BYPASS_EN
  assign w_bypass = !reset && w_empty && valid_in && w_credit;
`else
  assign w_bypass = 1'b0;
`endif

  assign ready_out = !reset && (r_count < CW'(DEPTH));
  assign valid_out = (!reset && !w_empty && w_credit) || w_bypass;

  always_comb begin
    if (w_bypass) begin
      op_out = op_in;
      a_out  = a_in;
      b_out  = b_in;
    end else begin
      {op_out, a_out, b_out} = w_head;
    end
  end

  assign w_enq = valid_in && ready_out;
  assign w_deq = valid_out && ready_in;
  // A bypassed triple that the ALU takes immediately never touches storage.
  assign w_push = w_enq && !(w_bypass && ready_in);
  assign w_pop  = w_deq && !w_empty;
  assign w_ret  = ret_valid && (r_inflight != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {op_in, a_in, b_in};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= r_inflight + IW'(w_deq) - IW'(w_ret);
    end
  end

  assign count_out    = r_count;
  assign inflight_out = r_inflight;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int MAXI  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in, b_in;
  logic        op_in, valid_in, ready_in, ret_valid;
  logic        ready_out, op_out, valid_out;
  logic [31:0] a_out, b_out;
  logic [2:0]  count_out;
  logic [1:0]  inflight_out;

  alu_issue_queue #(.WIDTH(32), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .valid_in(valid_in), .ready_out(ready_out), .a_out(a_out), .b_out(b_out),
    .op_out(op_out), .valid_out(valid_out), .ready_in(ready_in),
    .ret_valid(ret_valid), .count_out(count_out), .inflight_out(inflight_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } trip_t;

  trip_t q[$];
  int    infl;
  int    n_checks = 0;
  int    n_fail   = 0;

  logic        exp_ready, exp_valid, exp_byp, exp_op;
  logic [31:0] exp_a, exp_b;

  // Drive one cycle's inputs and derive the expected outputs from the model.
  task automatic apply(input logic vin, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic rdy, input logic ret);
    valid_in = vin; a_in = a; b_in = b; op_in = op; ready_in = rdy; ret_valid = ret;
    #1;
    exp_byp = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    exp_byp = !reset && q.size() == 0 && vin && infl < MAXI;
`endif
    exp_ready = !reset && q.size() < DEPTH;
    exp_valid = (!reset && q.size() > 0 && infl < MAXI) || exp_byp;
    if (exp_byp) begin
      exp_a = a; exp_b = b; exp_op = op;
    end else if (q.size() > 0) begin
      exp_a = q[0].a; exp_b = q[0].b; exp_op = q[0].op;
    end else begin
      exp_a = '0; exp_b = '0; exp_op = 1'b0;
    end
  endtask

  task automatic tick();
    logic enq, deq;
    trip_t t;
    if (reset) begin
      q.delete();
      infl = 0;
    end else begin
      enq = valid_in && exp_ready;
      deq = exp_valid && ready_in;
      if (deq && q.size() > 0) void'(q.pop_front());
      if (enq && !(exp_byp && ready_in)) begin
        t.a = a_in; t.b = b_in; t.op = op_in;
        q.push_back(t);
      end
      if (ret_valid && infl > 0) infl--;
      if (deq) infl++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(0, '0, '0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1, 32'h1234, 32'h5678, 1, 1, 1);
    n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b want=0", ready_out); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", valid_out); end
    tick();
    tick();
    reset = 1'b0;
    apply(0, '0, '0, 0, 0, 0);
    n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b want=1", ready_out); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got=%b want=0", valid_out); end
    n_checks++; if (count_out !== 3'd0 || inflight_out !== 2'd0) begin n_fail++; $display("FAIL post_rst_cnt got=%0d/%0d want=0/0", count_out, inflight_out); end
    n_checks++; if (a_out !== 32'h0 || b_out !== 32'h0 || op_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_data got=%h/%h/%b want=0", a_out, b_out, op_out); end
  endtask

  task automatic test_single_add();
    apply(1, 32'h3f800000, 32'h40000000, 0, 1, 0);
    n_checks++; if (valid_out !== exp_valid) begin n_fail++; $display("FAIL add_push_valid got=%b want=%b", valid_out, exp_valid); end
    tick();
    apply(0, '0, '0, 0, 1, 0);
`ifndef ALU_ISSUE_BYPASS_EN
    n_checks++; if (count_out !== 3'd1) begin n_fail++; $display("FAIL add_count1 got=%0d want=1", count_out); end
    n_checks++; if (valid_out !== 1'b1 || a_out !== 32'h3f800000 || b_out !== 32'h40000000 || op_out !== 1'b0)
      begin n_fail++; $display("FAIL add_out got=%b %h %h %b want=1 3f800000 40000000 0", valid_out, a_out, b_out, op_out); end
    tick();
    apply(0, '0, '0, 0, 1, 0);
`endif
    n_checks++; if (count_out !== 3'd0 || inflight_out !== 2'd1) begin n_fail++; $display("FAIL add_issued got=%0d/%0d want=0/1", count_out, inflight_out); end
    tick();
    apply(0, '0, '0, 0, 1, 1);
    tick();
    apply(0, '0, '0, 0, 1, 0);
    n_checks++; if (inflight_out !== 2'd0) begin n_fail++; $display("FAIL add_ret got=%0d want=0", inflight_out); end
    tick();
  endtask

  task automatic test_fill();
    trip_t pushed[5];
    int got = 0;
    logic pend = 1'b1;
    logic first_seen = 1'b0;
    logic after_first = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pushed[i].a = $urandom; pushed[i].b = $urandom; pushed[i].op = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1, pushed[i].a, pushed[i].b, pushed[i].op, 0, 0);
      n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL fill_accept%0d got=%b want=1", i, ready_out); end
      tick();
    end
    apply(1, pushed[4].a, pushed[4].b, pushed[4].op, 0, 0);
    n_checks++; if (ready_out !== 1'b0 || count_out !== 3'd4) begin n_fail++; $display("FAIL fill_full got=%b/%0d want=0/4", ready_out, count_out); end
    tick();
    for (int c = 0; c < 20 && got < 5; c++) begin
      apply(pend, pushed[4].a, pushed[4].b, pushed[4].op, 1, infl > 0);
      if (after_first) begin
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_deq got=%b want=1", ready_out); end
        after_first = 1'b0;
      end
      if (valid_out && !first_seen) begin
        n_checks++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL fill_no_comb_ready got=%b want=0", ready_out); end
        first_seen = 1'b1; after_first = 1'b1;
      end
      n_checks++; if (valid_out !== exp_valid) begin n_fail++; $display("FAIL fill_valid got=%b want=%b", valid_out, exp_valid); end
      if (exp_valid) begin
        n_checks++;
        if (a_out !== pushed[got].a || b_out !== pushed[got].b || op_out !== pushed[got].op) begin
          n_fail++; $display("FAIL fill_order%0d got=%h %h %b want=%h %h %b", got, a_out, b_out, op_out, pushed[got].a, pushed[got].b, pushed[got].op);
        end
        got++;
      end
      if (pend && exp_ready) pend = 1'b0;
      tick();
    end
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL fill_drain got=%0d want=5", got); end
  endtask

  task automatic test_credit_cap();
    trip_t t[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      t[i].a = $urandom; t[i].b = $urandom; t[i].op = 1'($urandom);
      apply(1, t[i].a, t[i].b, t[i].op, 0, 0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      apply(0, '0, '0, 0, 1, 0);
      n_checks++; if (valid_out !== (c < 2)) begin n_fail++; $display("FAIL credit_valid%0d got=%b want=%b", c, valid_out, c < 2); end
      tick();
    end
    apply(0, '0, '0, 0, 1, 1);
    n_checks++; if (valid_out !== 1'b0 || inflight_out !== 2'd2) begin n_fail++; $display("FAIL credit_ret_cycle got=%b/%0d want=0/2", valid_out, inflight_out); end
    tick();
    apply(0, '0, '0, 0, 1, 0);
    n_checks++; if (valid_out !== 1'b1 || a_out !== t[2].a) begin n_fail++; $display("FAIL credit_third got=%b %h want=1 %h", valid_out, a_out, t[2].a); end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    apply(1, $urandom, $urandom, 0, 0, 0); tick();
    apply(1, $urandom, $urandom, 1, 0, 0); tick();
    apply(0, '0, '0, 0, 1, 0); tick();
    apply(1, $urandom, $urandom, 0, 0, 0); tick();
    for (int c = 0; c < 8; c++) begin
      apply(1, $urandom, $urandom, 1'($urandom), 1, 1);
      n_checks++; if (count_out !== 3'd2 || inflight_out !== 2'd1) begin n_fail++; $display("FAIL simul_cnt%0d got=%0d/%0d want=2/1", c, count_out, inflight_out); end
      n_checks++; if (valid_out !== 1'b1 || a_out !== exp_a || b_out !== exp_b || op_out !== exp_op)
        begin n_fail++; $display("FAIL simul_head%0d got=%b %h want=1 %h", c, valid_out, a_out, exp_a); end
      tick();
    end
  endtask

  task automatic test_spurious_return();
    do_reset();
    apply(0, '0, '0, 0, 1, 1); tick();
    apply(0, '0, '0, 0, 1, 0);
    n_checks++; if (inflight_out !== 2'd0) begin n_fail++; $display("FAIL spurious_ret got=%0d want=0", inflight_out); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin apply(1, $urandom | 1, $urandom, 0, 0, 0); tick(); end
    for (int i = 0; i < 2; i++) begin apply(0, '0, '0, 0, 1, 0); tick(); end
    apply(1, $urandom | 1, $urandom, 1, 0, 0); tick();
    apply(0, '0, '0, 0, 0, 0);
    n_checks++; if (count_out !== 3'd3 || inflight_out !== 2'd2) begin n_fail++; $display("FAIL midrst_pre got=%0d/%0d want=3/2", count_out, inflight_out); end
    reset = 1'b1;
    apply(1, $urandom, $urandom, 1, 1, 1);
    n_checks++; if (ready_out !== 1'b0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL midrst_during got=%b/%b want=0/0", ready_out, valid_out); end
    tick();
    reset = 1'b0;
    apply(0, '0, '0, 0, 0, 0);
    n_checks++; if (count_out !== 3'd0 || inflight_out !== 2'd0 || valid_out !== 1'b0 || a_out !== 32'h0)
      begin n_fail++; $display("FAIL midrst_after got=%0d/%0d/%b/%h want=0/0/0/0", count_out, inflight_out, valid_out, a_out); end
    tick();
  endtask

`ifdef ALU_ISSUE_BYPASS_EN
  task automatic test_bypass();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    apply(1, a, 32'h5, 1, 1, 0);
    n_checks++; if (valid_out !== 1'b1 || a_out !== a || op_out !== 1'b1) begin n_fail++; $display("FAIL bypass_same got=%b %h want=1 %h", valid_out, a_out, a); end
    tick();
    apply(0, '0, '0, 0, 1, 0);
    n_checks++; if (count_out !== 3'd0 || inflight_out !== 2'd1) begin n_fail++; $display("FAIL bypass_cnt got=%0d/%0d want=0/1", count_out, inflight_out); end
    tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      apply(($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), ($urandom % 3) != 0,
            infl > 0 && ($urandom % 2) == 1);
      n_checks++;
      if (ready_out !== exp_ready || valid_out !== exp_valid || count_out !== 3'(q.size()) || inflight_out !== 2'(infl)) begin
        n_fail++; $display("FAIL rand_ctrl%0d got=%b %b %0d %0d want=%b %b %0d %0d", c, ready_out, valid_out, count_out, inflight_out, exp_ready, exp_valid, q.size(), infl);
      end
      if (exp_valid) begin
        n_checks++;
        if (a_out !== exp_a || b_out !== exp_b || op_out !== exp_op) begin
          n_fail++; $display("FAIL rand_data%0d got=%h %h %b want=%h %h %b", c, a_out, b_out, op_out, exp_a, exp_b, exp_op);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 0; a_in = '0; b_in = '0; op_in = 0; ready_in = 0; ret_valid = 0;
    infl = 0;
    @(negedge clk);
    test_reset();
    test_single_add();
    test_fill();
    test_credit_cap();
    test_simultaneous();
    test_spurious_return();
    test_mid_reset();
`ifdef ALU_ISSUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
